// File: rtl/jtag_seq.sv
// jtag_seq -- command-driven JTAG TAP sequencer.
// Accepts one command at a time (TAP reset, IR shift, DR shift, run-idle),
// plays it out as TCK bit-slots of 2*CLK_DIV clk cycles each and returns the
// TDO bits captured during the shift phase, right-aligned.
// Build option: define JTAG_SEQ_TRST_EN to also drive trst_no low for every
// slot of a TAP_RESET command; otherwise trst_no is tied high.
module jtag_seq #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_type_i,
    input  logic [6:0]  cmd_len_i,
    input  logic [63:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    output logic        trst_no,
    input  logic        tdo_i
);

    typedef enum logic [1:0] {
        CMD_TAP_RESET = 2'd0,
        CMD_SHIFT_IR  = 2'd1,
        CMD_SHIFT_DR  = 2'd2,
        CMD_RUN_IDLE  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SHIFT,
        ST_TRL,
        ST_RSP
    } state_e;

    // Phase counts clk cycles inside a slot: 0..2*CLK_DIV-1, plus one extra
    // tail value used only after the final slot, before the response is raised.
    localparam int PW = $clog2(2 * CLK_DIV + 1);
    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_END  = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_TAIL = PW'(2 * CLK_DIV);

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [6:0]    slot_q,  slot_d;
    cmd_e          type_q,  type_d;
    logic [6:0]    len_q,   len_d;
    logic [63:0]   data_q,  data_d;
    logic          tck_q,   tck_d;
    logic          tms_q,   tms_d;
    logic          tdi_q,   tdi_d;
    logic [63:0]   rsp_q,   rsp_d;
    logic          rst_q;

    logic       accept;
    logic       slot_start;
    logic       slots_done;
    logic       last_slot;
    logic [6:0] len_eff;

    // Index of the last header slot for each command type.
    function automatic logic [6:0] hdr_last(input cmd_e ct);
        logic [6:0] idx;
        case (ct)
            CMD_TAP_RESET: idx = 7'd5;
            CMD_SHIFT_IR:  idx = 7'd3;
            CMD_SHIFT_DR:  idx = 7'd2;
            default:       idx = 7'd0;
        endcase
        return idx;
    endfunction

    // TMS level for a given slot of a given phase.
    function automatic logic slot_tms(input state_e st, input cmd_e ct,
                                      input logic [6:0] len, input logic [6:0] slot);
        logic tms;
        case (st)
            ST_HDR: begin
                case (ct)
                    CMD_TAP_RESET: tms = (slot < 7'd5);
                    CMD_SHIFT_IR:  tms = (slot < 7'd2);
                    default:       tms = (slot == 7'd0);
                endcase
            end
            ST_SHIFT: tms = (ct != CMD_RUN_IDLE) && (slot == 7'(len - 7'd1));
            ST_TRL:   tms = (slot == 7'd0);
            default:  tms = 1'b0;
        endcase
        return tms;
    endfunction

    // TDI carries command data only during a real shift; zero otherwise.
    function automatic logic slot_tdi(input state_e st, input cmd_e ct,
                                      input logic [63:0] data, input logic [6:0] slot);
        return (st == ST_SHIFT) && (ct != CMD_RUN_IDLE) && data[slot[5:0]];
    endfunction

    // rst_q keeps cmd_ready_o low until the first edge after reset falls.
    assign cmd_ready_o = (state_q == ST_IDLE) && !rst_q;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_data_o  = rsp_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

    // State register: sequencing state and output drive flops.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        rst_q <= rst_i;
        if (rst_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            slot_q  <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            rsp_q   <= rsp_d;
        end
    end

    // Command registers: captured at acceptance, only read while busy.
    always_ff @(posedge clk_i) begin
        // NOTE: no reset here -- these are only ever read after an acceptance
        // has loaded them, so resetting them buys nothing.
        type_q <= type_d;
        len_q  <= len_d;
        data_q <= data_d;
    end

    // Next-state: acceptance, slot/phase stepping and phase transitions.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        phase_d    = phase_q;
        slot_d     = slot_q;
        type_d     = type_q;
        len_d      = len_q;
        data_d     = data_q;
        slot_start = 1'b0;
        slots_done = 1'b0;

        if (cmd_len_i == 7'd0)       len_eff = 7'd1;
        else if (cmd_len_i > 7'd64)  len_eff = 7'd64;
        else                         len_eff = cmd_len_i;

        case (state_q)
            ST_HDR:   last_slot = (slot_q == hdr_last(type_q));
            ST_SHIFT: last_slot = (slot_q == 7'(len_q - 7'd1));
            ST_TRL:   last_slot = (slot_q == 7'd1);
            default:  last_slot = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    type_d     = cmd_e'(cmd_type_i);
                    len_d      = len_eff;
                    data_d     = cmd_data_i;
                    phase_d    = '0;
                    slot_d     = '0;
                    slot_start = 1'b1;
                    state_d    = (cmd_e'(cmd_type_i) == CMD_RUN_IDLE) ? ST_SHIFT : ST_HDR;
                end
            end
            ST_HDR, ST_SHIFT, ST_TRL: begin
                if (phase_q == PH_TAIL) begin
                    state_d = ST_RSP;
                end else if (phase_q != PH_END) begin
                    phase_d = PW'(phase_q + 1'b1);
                end else if (!last_slot) begin
                    phase_d    = '0;
                    slot_d     = 7'(slot_q + 7'd1);
                    slot_start = 1'b1;
                end else if (state_q == ST_HDR && type_q != CMD_TAP_RESET) begin
                    state_d    = ST_SHIFT;
                    phase_d    = '0;
                    slot_d     = '0;
                    slot_start = 1'b1;
                end else if (state_q == ST_SHIFT && type_q != CMD_RUN_IDLE) begin
                    state_d    = ST_TRL;
                    phase_d    = '0;
                    slot_d     = '0;
                    slot_start = 1'b1;
                end else begin
                    phase_d    = PH_TAIL;
                    slots_done = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: TCK edges, per-slot TMS/TDI, TDO capture into the response.
    always_comb begin
        tck_d = tck_q;
        tms_d = tms_q;
        tdi_d = tdi_q;
        rsp_d = rsp_q;

        if (state_q == ST_IDLE) begin
            tck_d = 1'b0;
            tms_d = 1'b0;
            tdi_d = 1'b0;
        end
        if (accept) rsp_d = '0;

        if (slot_start) begin
            tck_d = 1'b0;
            tms_d = slot_tms(state_d, type_d, len_d, slot_d);
            tdi_d = slot_tdi(state_d, type_d, data_d, slot_d);
        end else if (slots_done) begin
            tck_d = 1'b0;
            tms_d = 1'b0;
            tdi_d = 1'b0;
        end else if ((state_q == ST_HDR || state_q == ST_SHIFT || state_q == ST_TRL)
                     && phase_q == PH_RISE) begin
            tck_d = 1'b1;
            if (state_q == ST_SHIFT && type_q != CMD_RUN_IDLE)
                rsp_d[slot_q[5:0]] = tdo_i;
        end
    end

`ifdef JTAG_SEQ_TRST_EN
    logic trst_q, trst_d;

    // TRST: low from acceptance of a TAP_RESET until its last slot ends.
    always_comb begin
        trst_d = trst_q;
        if (accept && cmd_e'(cmd_type_i) == CMD_TAP_RESET) trst_d = 1'b0;
        else if (slots_done)                               trst_d = 1'b1;
    end

    // TRST register.
    always_ff @(posedge clk_i) begin
        if (rst_i) trst_q <= 1'b1;
        else       trst_q <= trst_d;
    end

    assign trst_no = trst_q;
`else
    assign trst_no = 1'b1;
`endif

endmodule

// File: doc/jtag_seq.md
JTAG_SEQ -- requirements
Module: jtag_seq

Interface
- REQ-001: Parameter CLK_DIV, default 2, sets the TCK half-period in clk_i cycles; legal range is 1..255.
- REQ-002: clk_i  in  1  system clock; every flop is clocked on the rising edge.
- REQ-003: rst_i  in  1  reset; one clock, synchronous, active-high.
- REQ-004: cmd_valid_i  in  1  command valid.
- REQ-005: cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both high on the same edge.
- REQ-006: cmd_type_i  in  2  command type: 0=TAP_RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=RUN_IDLE.
- REQ-007: cmd_len_i  in  7  bit count (shift) or TCK count (RUN_IDLE).
- REQ-008: cmd_data_i  in  64  TDI data, sent LSB first.
- REQ-009: rsp_valid_o  out  1  response valid.
- REQ-010: rsp_ready_i  in  1  response consumer ready.
- REQ-011: rsp_data_o  out  64  captured TDO bits, right-aligned.
- REQ-012: tck_o, tms_o, tdi_o  out  1 each  JTAG drive signals.
- REQ-013: trst_no  out  1  JTAG TAP reset, active-low.
- REQ-014: tdo_i  in  1  JTAG data from the target.

Function
- REQ-015: Effective length is clamped: cmd_len_i=0 is treated as 1, and any value >64 is treated as 64.
- REQ-016: Each TCK bit-slot is 2*CLK_DIV clk cycles long.
  - tms_o and tdi_o are updated on the clk edge that drives tck_o low.
  - tck_o is high for the second CLK_DIV cycles of the slot.
  - tdo_i is sampled on the clk edge that drives tck_o high.
- REQ-017: States are IDLE, HDR, SHIFT, TRL, RSP.
  - cmd_ready_o is high only in IDLE.
- REQ-018: Acceptance moves the block IDLE->HDR. HDR emits the header TMS sequence:
  - TAP_RESET: 1,1,1,1,1,0.
  - SHIFT_DR: 1,0,0.
  - SHIFT_IR: 1,1,0,0.
  - RUN_IDLE: none (HDR is skipped).
- REQ-019: SHIFT emits len slots.
  - tdi_o = cmd_data_i[i] in slot i.
  - TMS=0 in every slot except the last, where TMS=1.
  - The TDO sample from slot i is stored into rsp_data_o[i].
  - Bits [63:len] of rsp_data_o are 0.
- REQ-020: TRL emits TMS 1,0 (Update -> Run-Test/Idle) for shift commands.
- REQ-021: RUN_IDLE emits len slots with TMS=0 and TDI=0.
- REQ-022: TAP_RESET and RUN_IDLE have no SHIFT or TRL phase and return rsp_data_o=0.
- REQ-023: cmd_data_i and cmd_type_i are registered at acceptance; later input changes have no effect.
- REQ-024: rsp_valid_o rises on the clk edge after the final slot completes (tck_o back low), and the block enters RSP.
- REQ-025: RSP->IDLE occurs on the edge where rsp_ready_i is high.
  - rsp_data_o holds stable while rsp_valid_o is high and rsp_ready_i is low.
- REQ-026: Accept-to-rsp_valid latency is (slots*2*CLK_DIV)+1 clk cycles, where slots is:
  - SHIFT_DR: len+5.
  - SHIFT_IR: len+6.
  - TAP_RESET: 6.
  - RUN_IDLE: len.
- REQ-027: The block holds only one command in flight; a new command is not accepted until the previous response has been consumed.
- REQ-028: In IDLE, tck_o=0, tms_o=0 and tdi_o=0.

Reset
- REQ-029: While rst_i is high, the block forces the following from the next edge on, regardless of state or mid-slot position:
  - state IDLE;
  - tck_o=0, tms_o=1, tdi_o=0, trst_no=1;
  - cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0.
  - Any pending response is discarded.
- REQ-030: cmd_ready_o rises on the first edge after rst_i falls.
- REQ-031: No TCK edge is produced until a command is accepted.

Configuration
- REQ-032: With macro JTAG_SEQ_TRST_EN defined, trst_no is driven low for every slot of a TAP_RESET command and returns high with the tck_o low that ends the last slot.
- REQ-033: With JTAG_SEQ_TRST_EN undefined, trst_no is a constant 1 and TAP_RESET uses TMS only.

Verification
- REQ-034: CLK_DIV=2, SHIFT_DR, len=32, data=0xDEADBEEF, target loopback TDI->TDO with a one-TCK delay:
  - TMS = 1,0,0, then 31x0, then 1,1,0.
  - TDI = 0xDEADBEEF LSB first.
  - rsp_valid_o at 37*4+1=149 cycles after accept.
  - rsp_data_o = {32'h0, ((0xDEADBEEF<<1)&0xFFFFFFFF) | d0}, where d0 is the TDO value during slot 0.
- REQ-035: SHIFT_IR, len=5, data=0x01, tdo_i tied 1:
  - TMS = 1,1,0,0,0,0,0,0,1,1,0.
  - rsp_data_o = 0x1F.
- REQ-036: TAP_RESET under both macro settings, CLK_DIV=1:
  - 6 slots with TMS 1,1,1,1,1,0.
  - trst_no low for 12 cycles only with JTAG_SEQ_TRST_EN.
  - rsp_data_o = 0.
- REQ-037: Boundaries:
  - cmd_len_i=0 on SHIFT_DR gives 6 slots and 1 captured bit.
  - cmd_len_i=100 gives 64 shifted bits.
  - RUN_IDLE len=3 gives 3 TCK pulses with TMS=0.
- REQ-038: Handshake and reset:
  - Hold rsp_ready_i=0 for 20 cycles: rsp_data_o stays stable and cmd_ready_o stays 0.
  - Assert rst_i mid-SHIFT (slot 10): next edge gives tck_o=0, tms_o=1, rsp_valid_o=0, and no response is ever emitted for that command.
